// File: rtl/core_bus_pkg.sv
// core_bus_pkg
//   Shared types for the multi-core bus arbiter: the arbiter FSM state
//   encoding, a bus request record (address, write data, write enable)
//   sized by the default bus widths, and a helper for index widths.
package core_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wr_data;
        logic                  wr_en;
    } bus_req_t;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_bus_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin select. The search starts at last_i+1
//   (mod N) and wraps, so the most recently served requester has the
//   lowest priority.
//   Ports:
//     req_i    in  N      request vector
//     last_i   in  IDX_W  index granted last time
//     grant_o  out IDX_W  winning index (0 when nothing requests)
//     valid_o  out 1      at least one request present
module rr_picker
    import core_bus_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(last_i) + i) % N);
            if (!valid_o && req_i[cand]) begin
                grant_o = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter
//   Round-robin arbiter letting NUM_CORES cores share one memory bus with
//   a req/ack handshake and an optional bounded wait (timeout -> error).
//   Ports:
//     clk_i, reset_ni                 clock, synchronous active-low reset
//     core_req_i/addr/wr_data/wr_en   per-core request fields (flattened)
//     core_ack_o                      one-hot single-cycle completion
//     core_err_o, core_rd_data_o      completion status / read data
//     mem_req_o/addr/wr_data/wr_en    registered request to memory
//     mem_rd_data_i, mem_ack_i        memory response
module core_bus_arbiter
    import core_bus_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic [NUM_CORES-1:0]          core_req_i,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr_i,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wr_data_i,
    input  logic [NUM_CORES-1:0]          core_wr_en_i,
    output logic [NUM_CORES-1:0]          core_ack_o,
    output logic                          core_err_o,
    output logic [DATA_W-1:0]             core_rd_data_o,
    output logic                          mem_req_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wr_data_o,
    output logic                          mem_wr_en_o,
    input  logic [DATA_W-1:0]             mem_rd_data_i,
    input  logic                          mem_ack_i
);

    localparam int IDX_W = idx_width(NUM_CORES);
    // Counter only exists meaningfully when a timeout is configured.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CORES - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [IDX_W-1:0]  pick;
    logic              pick_vld;

    rr_picker #(
        .N (NUM_CORES)
    ) u_picker (
        .req_i   (core_req_i),
        .last_i  (last_q),
        .grant_o (pick),
        .valid_o (pick_vld)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            grant_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    addr_d  = core_addr_i[int'(pick)*ADDR_W +: ADDR_W];
                    wdata_d = core_wr_data_i[int'(pick)*DATA_W +: DATA_W];
                    wen_d   = core_wr_en_i[pick];
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // An ack arriving on the last allowed cycle still wins.
                if (mem_ack_i) begin
                    rdata_d = wen_q ? '0 : mem_rd_data_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_ack_o = '0;
        if (state_q == RESP) begin
            core_ack_o[grant_q] = 1'b1;
        end
    end

    assign core_err_o     = err_q;
    assign core_rd_data_o = rdata_q;
    assign mem_req_o      = (state_q == BUSY);
    assign mem_addr_o     = addr_q;
    assign mem_wr_data_o  = wdata_q;
    assign mem_wr_en_o    = wen_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
module tb_core_bus_arbiter;
    import core_bus_pkg::*;

    localparam int NC = 4;

    logic              clk = 1'b0;
    logic              reset_ni;
    logic [NC-1:0]     req_v;
    logic [NC-1:0][31:0] addr_a;
    logic [NC-1:0][31:0] wdata_a;
    logic [NC-1:0]     wen_v;
    logic [NC-1:0]     core_ack;
    logic              core_err;
    logic [31:0]       core_rd;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wen;
    logic [31:0]       mem_rd;
    logic              mem_ack;

    int n_chk = 0;
    int n_bad = 0;
    int n_req;

    always #5 clk = ~clk;

    core_bus_arbiter #(
        .NUM_CORES      (NC),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .core_req_i     (req_v),
        .core_addr_i    (addr_a),
        .core_wr_data_i (wdata_a),
        .core_wr_en_i   (wen_v),
        .core_ack_o     (core_ack),
        .core_err_o     (core_err),
        .core_rd_data_o (core_rd),
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_wr_data_o  (mem_wdata),
        .mem_wr_en_o    (mem_wen),
        .mem_rd_data_i  (mem_rd),
        .mem_ack_i      (mem_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_core(input int i, input bus_req_t r);
        addr_a[i]  = r.addr;
        wdata_a[i] = r.wr_data;
        wen_v[i]   = r.wr_en;
        req_v[i]   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_ni = 1'b0;
        req_v    = '0;
        addr_a   = '0;
        wdata_a  = '0;
        wen_v    = '0;
        mem_rd   = '0;
        mem_ack  = 1'b0;
        tick();
        tick();
        check("rst_ack",   64'(core_ack), 64'h0);
        check("rst_req",   64'(mem_req), 64'h0);
        check("rst_addr",  64'(mem_addr), 64'h0);
        check("rst_rd",    64'(core_rd), 64'h0);
        reset_ni = 1'b1;
        tick();

        // Single read by core 2, ack 3 cycles after mem_req rises
        drive_core(2, '{addr: 32'h100, wr_data: 32'h0, wr_en: 1'b0});
        tick();
        check("rd_req",    64'(mem_req), 64'h1);
        check("rd_addr",   64'(mem_addr), 64'h100);
        check("rd_wen",    64'(mem_wen), 64'h0);
        tick();
        tick();
        check("rd_req_hold", 64'(mem_req), 64'h1);
        check("rd_noack",  64'(core_ack), 64'h0);
        mem_ack = 1'b1;
        mem_rd  = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        mem_rd  = '0;
        check("rd_ack",    64'(core_ack), 64'h4);
        check("rd_data",   64'(core_rd), 64'hDEADBEEF);
        check("rd_err",    64'(core_err), 64'h0);
        check("rd_req_off", 64'(mem_req), 64'h0);
        req_v = '0;
        tick();
        check("rd_ack_once", 64'(core_ack), 64'h0);

        // Write by core 1; memory returns junk that must be suppressed
        drive_core(1, '{addr: 32'h20, wr_data: 32'h12345678, wr_en: 1'b1});
        tick();
        check("wr_wen",    64'(mem_wen), 64'h1);
        check("wr_wdata",  64'(mem_wdata), 64'h12345678);
        check("wr_addr",   64'(mem_addr), 64'h20);
        tick();
        check("wr_wen_hold", 64'(mem_wen), 64'h1);
        mem_ack = 1'b1;
        mem_rd  = 32'hFFFFFFFF;
        tick();
        mem_ack = 1'b0;
        check("wr_ack",    64'(core_ack), 64'h2);
        check("wr_rd0",    64'(core_rd), 64'h0);
        check("wr_err",    64'(core_err), 64'h0);
        check("wr_wdata_resp", 64'(mem_wdata), 64'h12345678);
        req_v = '0;
        wen_v = '0;
        tick();

        // Timeout: core 3 read, memory never acks
        drive_core(3, '{addr: 32'h300, wr_data: 32'h0, wr_en: 1'b0});
        mem_rd = 32'hAAAA5555;
        tick();
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            n_req++;
            tick();
        end
        check("to_req_cycles", 64'(n_req), 64'd8);
        check("to_ack",    64'(core_ack), 64'h8);
        check("to_err",    64'(core_err), 64'h1);
        check("to_rd0",    64'(core_rd), 64'h0);
        req_v = '0;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_ack", 64'(core_ack), 64'h0);
        check("stray_req", 64'(mem_req), 64'h0);
        tick();
        check("stray_ack2", 64'(core_ack), 64'h0);

        // Ack on the final allowed cycle: ack wins over timeout
        drive_core(0, '{addr: 32'h40, wr_data: 32'h0, wr_en: 1'b0});
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("race_req8", 64'(mem_req), 64'h1);
        mem_ack = 1'b1;
        mem_rd  = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        mem_rd  = '0;
        check("race_ack",  64'(core_ack), 64'h1);
        check("race_err",  64'(core_err), 64'h0);
        check("race_data", 64'(core_rd), 64'hCAFEF00D);
        req_v = '0;
        tick();

        // Reset in the middle of a BUSY access
        drive_core(2, '{addr: 32'h200, wr_data: 32'h99, wr_en: 1'b1});
        tick();
        check("mr_addr",   64'(mem_addr), 64'h200);
        reset_ni = 1'b0;
        tick();
        check("mr_req",    64'(mem_req), 64'h0);
        check("mr_addr0",  64'(mem_addr), 64'h0);
        check("mr_wdata0", 64'(mem_wdata), 64'h0);
        check("mr_wen0",   64'(mem_wen), 64'h0);
        check("mr_rd0",    64'(core_rd), 64'h0);
        check("mr_err0",   64'(core_err), 64'h0);
        check("mr_ack0",   64'(core_ack), 64'h0);
        reset_ni = 1'b1;

        // Fairness: all cores request, ack on first BUSY cycle
        for (int i = 0; i < NC; i++)
            drive_core(i, '{addr: 32'h1000 + 32'(i * 4), wr_data: 32'h0, wr_en: 1'b0});
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_req",  64'(mem_req), 64'h1);
            check("rr_addr", 64'(mem_addr), 64'h1000 + 64'((k % NC) * 4));
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            check("rr_ack",  64'(core_ack), 64'(1 << (k % NC)));
            tick();
            check("rr_idle_req", 64'(mem_req), 64'h0);
            check("rr_idle_ack", 64'(core_ack), 64'h0);
        end
        req_v = '0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
